// File: rtl/riscv_muldiv_pkg.sv
// Shared decode for the M-extension unit: funct3 codes, FSM states and
// operand-signedness helpers used at request accept.
package riscv_muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  // mul treats a as signed; only its low half is kept, so the choice is free
  function automatic logic is_signed_a(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
           (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic is_signed_b(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/riscv_muldiv_divstep.sv
// One restoring-division step: shift in the next dividend bit, subtract the
// divisor if it fits. Purely combinational, no handshake.
module riscv_muldiv_divstep #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic            dividend_bit,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic            quo_bit
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // rem < divisor keeps shifted - divisor inside (-2^XLEN, 2^XLEN), so the
  // top bit of the XLEN+1 bit difference is a clean borrow flag
  assign shifted  = {rem, dividend_bit};
  assign diff     = shifted - {1'b0, divisor};
  assign quo_bit  = ~diff[XLEN];
  assign rem_next = quo_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];

endmodule

// File: rtl/riscv_muldiv.sv
// Iterative RV M-extension unit: one op at a time, result registered in DONE
// and held until out_ready; in_ready only when idle or the result is leaving.
module riscv_muldiv
  import riscv_muldiv_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MUL_BITS = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t state, state_next, start_state;

  logic              accept;
  logic              a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              fast;
  logic [XLEN-1:0]   fast_res;

  logic [2:0]        op;
  logic              neg_q;     // sign of product / quotient
  logic              neg_r;     // sign of remainder
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] mcand;
  logic [XLEN-1:0]   mplier;    // multiplier, or divisor magnitude
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [CW-1:0]     cnt;

  logic [2*XLEN-1:0] partial, acc_sum, prod;
  logic [XLEN-1:0]   mplier_next;
  logic              mul_last;
  logic [XLEN-1:0]   rem_nx, quo_nx, rem_fin, quo_fin;
  logic              quo_bit;

  assign in_ready  = ~reset && ((state == IDLE) || ((state == DONE) && out_ready));
  assign accept    = in_valid && in_ready && ~kill;
  assign out_valid = (state == DONE);

  assign a_neg = is_signed_a(funct3) && operand_a[XLEN-1];
  assign b_neg = is_signed_b(funct3) && operand_b[XLEN-1];
  assign a_mag = a_neg ? -operand_a : operand_a;
  assign b_mag = b_neg ? -operand_b : operand_b;

  always_comb begin
    fast     = 1'b0;
    fast_res = '0;
    case (funct3)
      F3_MUL, F3_MULH, F3_MULHSU, F3_MULHU: begin
        fast = (operand_a == '0) || (operand_b == '0);
      end
      F3_DIV, F3_REM: begin
        if (operand_b == '0) begin
          fast     = 1'b1;
          fast_res = (funct3 == F3_REM) ? operand_a : '1;
        end else if ((operand_a == MOST_NEG) && (operand_b == '1)) begin
          fast     = 1'b1;
          fast_res = (funct3 == F3_REM) ? '0 : MOST_NEG;
        end
      end
      F3_DIVU, F3_REMU: begin
        if (operand_b == '0) begin
          fast     = 1'b1;
          fast_res = (funct3 == F3_REMU) ? operand_a : '1;
        end
      end
      default: begin
        fast = 1'b0;
      end
    endcase
  end

  // Multiply step: add |a| times the next MUL_BITS multiplier bits
  always_comb begin
    partial = '0;
    for (int i = 0; i < MUL_BITS; i++) begin
      if (mplier[i]) begin
        partial = partial + (mcand << i);
      end
    end
    acc_sum     = acc + partial;
    mplier_next = mplier >> MUL_BITS;
    prod        = neg_q ? -acc_sum : acc_sum;
  end

  assign mul_last = (mplier_next == '0);

  riscv_muldiv_divstep #(.XLEN(XLEN)) u_divstep (
    .rem          (rem),
    .dividend_bit (quo[XLEN-1]),
    .divisor      (mplier),
    .rem_next     (rem_nx),
    .quo_bit      (quo_bit)
  );

  assign quo_nx  = {quo[XLEN-2:0], quo_bit};
  assign quo_fin = neg_q ? -quo_nx : quo_nx;
  assign rem_fin = neg_r ? -rem_nx : rem_nx;

  always_comb begin
    start_state = funct3[2] ? DIV : MUL;
    if (fast) begin
      start_state = DONE;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) state_next = start_state;
      end
      MUL: begin
        if (mul_last) state_next = DONE;
      end
      DIV: begin
        if (cnt == '0) state_next = DONE;
      end
      DONE: begin
        if (accept)         state_next = start_state;
        else if (out_ready) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (kill) begin
      state_next = IDLE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      result <= '0;
      op     <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      quo    <= '0;
      rem    <= '0;
      cnt    <= '0;
    end else if (accept) begin
      op     <= funct3;
      neg_q  <= a_neg ^ b_neg;
      neg_r  <= a_neg;
      acc    <= '0;
      mcand  <= {{XLEN{1'b0}}, a_mag};
      mplier <= b_mag;
      quo    <= a_mag;
      rem    <= '0;
      cnt    <= CW'(XLEN-1);
      if (fast) begin
        result <= fast_res;
      end
    end else if (~kill) begin
      case (state)
        MUL: begin
          acc    <= acc_sum;
          mcand  <= mcand << MUL_BITS;
          mplier <= mplier_next;
          if (mul_last) begin
            result <= (op == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
          end
        end
        DIV: begin
          rem <= rem_nx;
          quo <= quo_nx;
          cnt <= cnt - CW'(1);
          if (cnt == '0) begin
            result <= ((op == F3_REM) || (op == F3_REMU)) ? rem_fin : quo_fin;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
